multicycle_control_unit: RTL

//  Multicycle MIPS control FSM; successor to the single-cycle combinational control_unit.

---
 rtl/multicycle_control_unit.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: multicycle MIPS control FSM with memory handshake, error detection and retire counter
// Optional feature: define MULTICYCLE_JUMP_EN to decode opcode 0x02 as a jump; otherwise 0x02 is illegal.
// Ports: clock, reset (async, active-low); opcode, funct, zero, mem_ready in;
//   MemRead/MemWrite/IorD/IRWrite, RegDst/MemToReg/RegWrite, ALUsrcA/ALUsrcB, PCSource, pc_en, ALU_Ctrl,
//   state (debug), instr_done, instr_cnt, err, err_code out.
module multicycle_control_unit #(
   parameter int MEM_TIMEOUT = 16,
   parameter int TO_W        = 5,
   parameter int CNT_W       = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic [5:0]       funct,
   input  logic             zero,
   input  logic             mem_ready,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IorD,
   output logic             IRWrite,
   output logic             RegDst,
   output logic             MemToReg,
   output logic             RegWrite,
   output logic             ALUsrcA,
   output logic [1:0]       ALUsrcB,
   output logic [1:0]       PCSource,
   output logic             pc_en,
   output logic [5:0]       ALU_Ctrl,
   output logic [3:0]       state,
   output logic             instr_done,
   output logic [CNT_W-1:0] instr_cnt,
   output logic             err,
   output logic [1:0]       err_code
);
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXEC   = 4'd6,
      ALUWB  = 4'd7,
      BRANCH = 4'd8,
      ADDIEX = 4'd9,
      ADDIWB = 4'd10,
`ifdef MULTICYCLE_JUMP_EN
      JUMP   = 4'd11,
`endif
      ERROR  = 4'd15
   } state_t;
   state_t          st, nxt;
   logic [1:0]      nxt_code;
   logic [TO_W-1:0] wait_cnt;
   logic            waiting, timeout, funct_ok;
   assign funct_ok = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27};
   assign waiting  = (st == FETCH || st == MEMRD || st == MEMWR) && !mem_ready;
   // a ready on the deadline cycle completes the access instead of timing out
   assign timeout  = waiting && (MEM_TIMEOUT > 0) && wait_cnt == TO_W'(MEM_TIMEOUT - 1);
   assign state    = st;
   assign err      = st == ERROR;
   always_comb begin
      nxt      = st;
      nxt_code = err_code;
      case (st)
         FETCH:  nxt = mem_ready ? DECODE : FETCH;
         DECODE:
            case (opcode)
               6'h23, 6'h2B: nxt = MEMADR;
               6'h00:        nxt = EXEC;
               6'h08:        nxt = ADDIEX;
               6'h04:        nxt = BRANCH;
`ifdef MULTICYCLE_JUMP_EN
               6'h02:        nxt = JUMP;
`endif
               default: begin
                  nxt      = ERROR;
                  nxt_code = 2'b01;
               end
            endcase
         MEMADR: nxt = opcode == 6'h23 ? MEMRD : MEMWR;
         MEMRD:  nxt = mem_ready ? MEMWB : MEMRD;
         MEMWR:  nxt = mem_ready ? FETCH : MEMWR;
         EXEC: begin
            nxt      = funct_ok ? ALUWB : ERROR;
            nxt_code = funct_ok ? err_code : 2'b10;
         end
         ADDIEX: nxt = ADDIWB;
         MEMWB, ALUWB, BRANCH, ADDIWB: nxt = FETCH;
`ifdef MULTICYCLE_JUMP_EN
         JUMP:   nxt = FETCH;
`endif
         ERROR:  nxt = ERROR;
         default: begin
            nxt      = ERROR;
            nxt_code = 2'b01;
         end
      endcase
      if (timeout) begin
         nxt      = ERROR;
         nxt_code = 2'b11;
      end
   end
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         st        <= FETCH;
         err_code  <= 2'b00;
         wait_cnt  <= '0;
         instr_cnt <= '0;
      end else begin
         st        <= nxt;
         err_code  <= nxt_code;
         wait_cnt  <= (waiting && nxt == st) ? wait_cnt + TO_W'(1) : '0;
         if (instr_done) instr_cnt <= instr_cnt + CNT_W'(1);
      end
   always_comb begin
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemToReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUsrcA    = 1'b0;
      ALUsrcB    = 2'b00;
      PCSource   = 2'b00;
      pc_en      = 1'b0;
      ALU_Ctrl   = 6'h20;
      instr_done = 1'b0;
      case (st)
         FETCH: begin
            MemRead = 1'b1;
            ALUsrcB = 2'b01;
            IRWrite = mem_ready;
            pc_en   = mem_ready;
         end
         DECODE: ALUsrcB = 2'b11;
         MEMADR: begin
            ALUsrcA = 1'b1;
            ALUsrcB = 2'b10;
         end
         MEMRD: begin
            MemRead = 1'b1;
            IorD    = 1'b1;
         end
         MEMWB: begin
            MemToReg   = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         MEMWR: begin
            MemWrite   = 1'b1;
            IorD       = 1'b1;
            instr_done = mem_ready;
         end
         EXEC: begin
            ALUsrcA  = 1'b1;
            ALU_Ctrl = funct_ok ? funct : 6'h20;
         end
         ALUWB: begin
            RegDst     = 1'b1;
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
         BRANCH: begin
            ALUsrcA    = 1'b1;
            ALU_Ctrl   = 6'h22;
            PCSource   = 2'b01;
            pc_en      = zero;
            instr_done = 1'b1;
         end
         ADDIEX: begin
            ALUsrcA = 1'b1;
            ALUsrcB = 2'b10;
         end
         ADDIWB: begin
            RegWrite   = 1'b1;
            instr_done = 1'b1;
         end
`ifdef MULTICYCLE_JUMP_EN
         JUMP: begin
            PCSource   = 2'b10;
            pc_en      = 1'b1;
            instr_done = 1'b1;
         end
`endif
         default: ;
      endcase
   end
endmodule
